// File: rtl/ad_cap_pkg.sv
// ---------------------------------------------------------------------------
// ad_cap_pkg
// Shared definitions for the ADC clock/capture block:
//   DIV_W        width of the divider count / AD_DivCnt input
//   cap_phase_e  capture phase encodings (quarter steps of the divided period)
//   cap_point()  counter value at which a sample is taken for a given phase
// ---------------------------------------------------------------------------
package ad_cap_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        PH_0   = 2'b00,
        PH_90  = 2'b01,
        PH_180 = 2'b10,
        PH_270 = 2'b11
    } cap_phase_e;

    // Capture point inside a period of N = divcnt+1 clocks. The period is
    // widened to DIV_W+1 bits so that divcnt = 255 (N = 256) does not wrap.
    function automatic logic [DIV_W:0] cap_point(input logic [DIV_W-1:0] divcnt,
                                                 input logic [1:0]       phase);
        logic [DIV_W:0] n;
        n = {1'b0, divcnt} + (DIV_W+1)'(1);
        case (cap_phase_e'(phase))
            PH_0:    cap_point = '0;
            PH_90:   cap_point = n >> 2;
            PH_180:  cap_point = n >> 1;
            default: cap_point = (n >> 2) + (n >> 1);
        endcase
    endfunction

endpackage

// File: rtl/ad_cap_fifo.sv
// ---------------------------------------------------------------------------
// ad_cap_fifo
// Synchronous first-word-fall-through FIFO for captured ADC samples.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst  system clock, synchronous active-high reset (flushes the FIFO)
//   push      write request, wdata written on the clock edge if accepted
//   full      FIFO holds DEPTH entries
//   pop       read request, ignored while empty
//   rdata     oldest entry, forced to zero while empty
//   empty     FIFO holds no entries
//   drop      push refused this cycle (full and no pop)
// ---------------------------------------------------------------------------
module ad_cap_fifo
    import ad_cap_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // addresses with differing wrap bits mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO still fits when the head leaves in the same
    // cycle; the slot being overwritten is the one being read out.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage array, no reset needed: contents are only visible through
    // rdata, which is gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ad_clk_capture.sv
// ---------------------------------------------------------------------------
// ad_clk_capture
// Receive-side ADC interface: divides clk into the ADC sample clock, captures
// parallel ADC data at a programmable phase of each divided period and
// buffers the samples in a small FWFT FIFO (valid/ready to the consumer).
// Parameters: DATA_W (sample width), FIFO_DEPTH (power of two, >= 2).
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   Clk_Syn      resync pulse, restarts the divider period
//   Clk_Phase    capture phase select (PH_0/PH_90/PH_180/PH_270)
//   AD_DivCnt    divided period minus one, in clk cycles (0 = stopped)
//   ad_data_i    ADC parallel data
//   ad_clk_o     divided sample clock to the ADC
//   smp_data     oldest buffered sample (0 when none)
//   smp_valid    FIFO not empty
//   smp_ready    consumer accepts smp_data when smp_valid && smp_ready
//   ovf_o        sticky overflow flag, set when a sample is dropped
//   ovf_clr      clears ovf_o (a new overflow in the same cycle wins)
// Optional feature (macro AD_CAP_OTR_EN):
//   ad_otr_i     ADC out-of-range bit, stored alongside each sample
//   smp_otr      out-of-range bit of smp_data (0 when none)
// ---------------------------------------------------------------------------
module ad_clk_capture
    import ad_cap_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Clk_Syn,
    input  logic [1:0]        Clk_Phase,
    input  logic [DIV_W-1:0]  AD_DivCnt,
    input  logic [DATA_W-1:0] ad_data_i,
    output logic              ad_clk_o,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              ovf_o,
`ifdef AD_CAP_OTR_EN
    input  logic              ad_otr_i,
    output logic              smp_otr,
`endif
    input  logic              ovf_clr
);

`ifdef AD_CAP_OTR_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W:0]    cnt_ext;
    logic [DIV_W:0]    n_period;
    logic [DIV_W:0]    cap_pt;
    logic              div_en;
    logic              cap_stb;
    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_rdata;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              fifo_full_unused;

    // Period and capture point are computed one bit wider than the counter
    // so that AD_DivCnt = 255 gives N = 256 without wrapping.
    assign n_period = {1'b0, AD_DivCnt} + (DIV_W+1)'(1);
    assign cnt_ext  = {1'b0, cnt};
    assign cap_pt   = cap_point(AD_DivCnt, Clk_Phase);
    assign div_en   = (AD_DivCnt != '0);

    // A resync cycle never captures: the period it would belong to is being
    // abandoned.
    assign cap_stb  = (cnt_ext == cap_pt) && div_en && !Clk_Syn;

    // Period counter. If AD_DivCnt is lowered below the current count the
    // "else" branch wraps it to zero on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (Clk_Syn) begin
            cnt <= '0;
        end else if (cnt < AD_DivCnt) begin
            cnt <= cnt + DIV_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Sample clock: low for the first half of the period, high for the
    // second half, registered so it is glitch-free at the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            ad_clk_o <= 1'b0;
        end else begin
            ad_clk_o <= div_en && (cnt_ext >= (n_period >> 1));
        end
    end

`ifdef AD_CAP_OTR_EN
    assign fifo_wdata = {ad_otr_i, ad_data_i};
    assign smp_otr    = fifo_rdata[DATA_W];
`else
    assign fifo_wdata = ad_data_i;
`endif

    // The FIFO forces rdata to zero while empty, so smp_data (and smp_otr)
    // need no further gating here.
    assign smp_data  = fifo_rdata[DATA_W-1:0];
    assign smp_valid = !fifo_empty;

    ad_cap_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_stb),
        .wdata (fifo_wdata),
        .full  (fifo_full_unused),
        .pop   (smp_ready),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    // Sticky overflow: a dropped sample sets the flag even when ovf_clr is
    // asserted in the same cycle, so no overflow event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else if (fifo_drop) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr) begin
            ovf_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad_clk_capture.sv
// ---------------------------------------------------------------------------
// tb_ad_clk_capture
// Directed bench for ad_clk_capture. A cycle model of the divider, clock and
// sample queue predicts every output; captured samples are pushed to the
// expected queue when the strobe fires and popped when the consumer takes
// them. Directed checks cover duty cycle, capture spacing, overflow, the
// full-with-pop case and reset.
// ---------------------------------------------------------------------------
module tb_ad_clk_capture;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              Clk_Syn;
    logic [1:0]        Clk_Phase;
    logic [7:0]        AD_DivCnt;
    logic [DATA_W-1:0] ad_data_i;
    logic              ad_clk_o;
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic              smp_ready;
    logic              ovf_o;
    logic              ovf_clr;
`ifdef AD_CAP_OTR_EN
    logic              ad_otr_i = 1'b0;
    logic              smp_otr;
`endif

    int nCompared = 0;
    int nFailed   = 0;

    // cycle model state
    int m_cnt;
    bit m_clk;
    bit m_ovf;
    int m_q[$];
    int popLog[$];
    int strobeCount;
    int highCount;
    int cycleNo;

    ad_clk_capture #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Clk_Syn   (Clk_Syn),
        .Clk_Phase (Clk_Phase),
        .AD_DivCnt (AD_DivCnt),
        .ad_data_i (ad_data_i),
        .ad_clk_o  (ad_clk_o),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .ovf_o     (ovf_o),
`ifdef AD_CAP_OTR_EN
        .ad_otr_i  (ad_otr_i),
        .smp_otr   (smp_otr),
`endif
        .ovf_clr   (ovf_clr)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic syn, input logic [1:0] ph,
                                 input logic [7:0] div, input logic rdy, input logic clr);
        rst       = r;
        Clk_Syn   = syn;
        Clk_Phase = ph;
        AD_DivCnt = div;
        smp_ready = rdy;
        ovf_clr   = clr;
    endtask

    function automatic int modelCapPt(input int div, input int ph);
        int n;
        n = div + 1;
        case (ph)
            0:       return 0;
            1:       return n / 4;
            2:       return n / 2;
            default: return n / 4 + n / 2;
        endcase
    endfunction

    function automatic bit modelStrobe();
        return (m_cnt == modelCapPt(int'(AD_DivCnt), int'(Clk_Phase))) &&
               (AD_DivCnt != 8'd0) && !Clk_Syn;
    endfunction

    // Advance model and DUT by one clock, then compare all outputs.
    task automatic step();
        bit stb;
        bit popNow;
        int sizeBefore;
        int n;
        logic [31:0] expData;
        if (smp_valid === 1'b1 && smp_ready) popLog.push_back(int'(smp_data));
        if (rst) begin
            m_cnt = 0;
            m_clk = 1'b0;
            m_ovf = 1'b0;
            m_q.delete();
        end else begin
            n          = int'(AD_DivCnt) + 1;
            stb        = modelStrobe();
            popNow     = smp_ready && (m_q.size() != 0);
            sizeBefore = m_q.size();
            m_clk      = (AD_DivCnt != 8'd0) && (m_cnt >= n / 2);
            if (Clk_Syn) m_cnt = 0;
            else if (m_cnt < int'(AD_DivCnt)) m_cnt = m_cnt + 1;
            else m_cnt = 0;
            if (popNow) void'(m_q.pop_front());
            if (stb) begin
                strobeCount++;
                if (sizeBefore < DEPTH || popNow) m_q.push_back(int'(ad_data_i));
                else m_ovf = 1'b1;
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
            end
            if (stb && sizeBefore >= DEPTH && !popNow) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
        @(negedge clk);
        cycleNo++;
        ad_data_i = cycleNo[DATA_W-1:0];
        if (ad_clk_o === 1'b1) highCount++;
        expData = (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0;
        checkOutput("ad_clk_o", 32'(ad_clk_o), 32'(m_clk));
        checkOutput("smp_valid", 32'(smp_valid), 32'(m_q.size() != 0));
        checkOutput("smp_data", 32'(smp_data), expData);
        checkOutput("ovf_o", 32'(ovf_o), 32'(m_ovf));
    endtask

    initial begin
        bit found;
        cycleNo   = 0;
        ad_data_i = '0;
        m_cnt     = 0;
        m_clk     = 1'b0;
        m_ovf     = 1'b0;
        strobeCount = 0;
        highCount   = 0;

        // Reset
        applyStimulus(1'b1, 1'b0, 2'b00, 8'd7, 1'b1, 1'b0);
        repeat (3) step();
        checkOutput("rst_valid", 32'(smp_valid), 32'd0);
        checkOutput("rst_data", 32'(smp_data), 32'd0);
        checkOutput("rst_adclk", 32'(ad_clk_o), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_o), 32'd0);

        // 1: period 8, phase 0, consumer always ready
        $display("[TB] test 1: divide by 8, phase 0");
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b1, 1'b0);
        repeat (16) step();
        highCount = 0;
        popLog.delete();
        repeat (32) step();
        checkOutput("t1_clk_high_cycles", 32'(highCount), 32'd16);
        checkOutput("t1_pop_count", 32'(popLog.size()), 32'd4);
        for (int i = 0; i + 1 < popLog.size(); i++)
            checkOutput("t1_pop_step", 32'(popLog[i+1] - popLog[i]), 32'd8);

        // 2: other phases and periods
        $display("[TB] test 2: phases and periods");
        applyStimulus(1'b0, 1'b0, 2'b10, 8'd7, 1'b1, 1'b0);
        repeat (24) step();
        applyStimulus(1'b0, 1'b0, 2'b11, 8'd7, 1'b1, 1'b0);
        repeat (24) step();
        applyStimulus(1'b0, 1'b0, 2'b11, 8'd9, 1'b1, 1'b0);
        repeat (30) step();
        applyStimulus(1'b0, 1'b0, 2'b01, 8'd11, 1'b1, 1'b0);
        repeat (36) step();

        // 3: resync pulse at cnt == 5
        $display("[TB] test 3: resync");
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_cnt == 5) found = 1'b1;
            else step();
        end
        checkOutput("t3_find_cnt5", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b1, 2'b00, 8'd7, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b1, 1'b0);
        repeat (24) step();

        // 4: overflow with consumer stalled, then drain and clear
        $display("[TB] test 4: overflow");
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_q.size() == 0) found = 1'b1;
            else step();
        end
        checkOutput("t4_empty_wait", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b0, 1'b0);
        strobeCount = 0;
        for (int i = 0; i < 200 && strobeCount < 9; i++) step();
        checkOutput("t4_nine_captures", 32'(strobeCount), 32'd9);
        checkOutput("t4_ovf_set", 32'(ovf_o), 32'd1);
        checkOutput("t4_valid_full", 32'(smp_valid), 32'd1);
        popLog.delete();
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b1, 1'b0);
        repeat (8) step();
        checkOutput("t4_drain_count", 32'(popLog.size()), 32'd8);
        for (int i = 0; i + 1 < popLog.size() && i < 7; i++)
            checkOutput("t4_drain_order", 32'(popLog[i+1] - popLog[i]), 32'd8);
        checkOutput("t4_ovf_sticky", 32'(ovf_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b1, 1'b0);
        checkOutput("t4_ovf_clr", 32'(ovf_o), 32'd0);

        // 5: full FIFO, consumer ready exactly on the capture cycle
        $display("[TB] test 5: push into full FIFO with pop");
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_q.size() < DEPTH; i++) step();
        checkOutput("t5_fill", 32'(m_q.size()), 32'(DEPTH));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (modelStrobe()) found = 1'b1;
            else step();
        end
        checkOutput("t5_find_strobe", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b0, 1'b0);
        checkOutput("t5_no_ovf", 32'(ovf_o), 32'd0);
        repeat (8) step();
        checkOutput("t5_still_full_ovf", 32'(ovf_o), 32'd1);

        // 6: reset with samples buffered, then divider stopped
        $display("[TB] test 6: reset mid-operation");
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd7, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (m_q.size() == 3) found = 1'b1;
            else step();
        end
        checkOutput("t6_three_buffered", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b0, 2'b00, 8'd7, 1'b0, 1'b0);
        step();
        checkOutput("t6_valid", 32'(smp_valid), 32'd0);
        checkOutput("t6_data", 32'(smp_data), 32'd0);
        checkOutput("t6_adclk", 32'(ad_clk_o), 32'd0);
        checkOutput("t6_ovf", 32'(ovf_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd0, 1'b1, 1'b0);
        highCount = 0;
        repeat (24) step();
        checkOutput("t6_div0_valid", 32'(smp_valid), 32'd0);
        checkOutput("t6_div0_clk_high", 32'(highCount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
